// File: rtl/sprite_layer_renderer.sv
// Sprite layer renderer: NUM_CH integer-scaled sprites composited by channel priority, 3-cycle pipeline.
// Define SPRITE_FLIP_EN to build per-channel horizontal mirroring; otherwise ch_flip_h is ignored.
module sprite_layer_renderer #(
   parameter int NUM_CH     = 4,
   parameter int SPR_W      = 16,
   parameter int SPR_H      = 16,
   parameter int ADDR_W     = 8,
   parameter int IDX_W      = 4,
   parameter int SCALE_W    = 2,
   parameter int TRANSP_IDX = 0,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      vga_clk,
   input  logic                      reset,
   input  logic [9:0]                DrawX,
   input  logic [9:0]                DrawY,
   input  logic                      blank,
   input  logic [NUM_CH-1:0]         ch_en,
   input  logic [NUM_CH*10-1:0]      ch_x,
   input  logic [NUM_CH*10-1:0]      ch_y,
   input  logic [NUM_CH*SCALE_W-1:0] ch_scale,
   input  logic [NUM_CH-1:0]         ch_flip_h,
   output logic [NUM_CH*ADDR_W-1:0]  rom_addr,
   input  logic [NUM_CH*IDX_W-1:0]   rom_q,
   output logic [IDX_W-1:0]          pix_idx,
   output logic [CH_W-1:0]           pix_ch,
   output logic                      pix_opaque,
   output logic                      pix_blank
);
   localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
   localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;

   logic                      w_cap;
   logic [NUM_CH-1:0]         r_sh_en, w_en;
   logic [NUM_CH*10-1:0]      r_sh_x, r_sh_y, w_x, w_y;
   logic [NUM_CH*SCALE_W-1:0] r_sh_sc, w_sc;
   logic [NUM_CH-1:0]         w_hit, r_hit1, r_hit2;
   logic [NUM_CH*ADDR_W-1:0]  w_addr;
   logic                      r_blank1, r_blank2;
   logic                      w_win;
   logic [IDX_W-1:0]          w_win_idx;
   logic [CH_W-1:0]           w_win_ch;

   // The capture cycle renders with the values being captured so a sprite at the origin is not lost.
   assign w_cap = (DrawX == 10'd0) && (DrawY == 10'd0);
   assign w_en  = w_cap ? ch_en    : r_sh_en;
   assign w_x   = w_cap ? ch_x     : r_sh_x;
   assign w_y   = w_cap ? ch_y     : r_sh_y;
   assign w_sc  = w_cap ? ch_scale : r_sh_sc;

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_sh_en <= '0;
         r_sh_x  <= '0;
         r_sh_y  <= '0;
         r_sh_sc <= '0;
      end else if (w_cap) begin
         r_sh_en <= ch_en;
         r_sh_x  <= ch_x;
         r_sh_y  <= ch_y;
         r_sh_sc <= ch_scale;
      end
   end

`ifdef SPRITE_FLIP_EN
   logic [NUM_CH-1:0] r_sh_flip, w_flip;
   assign w_flip = w_cap ? ch_flip_h : r_sh_flip;
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset)      r_sh_flip <= '0;
      else if (w_cap) r_sh_flip <= ch_flip_h;
   end
`else
   logic w_unused_flip;
   assign w_unused_flip = |ch_flip_h;
`endif

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [9:0]         w_cx, w_cy;
      logic [SCALE_W-1:0] w_csc;
      logic               r_ract, w_ract, r_cact, w_cact;
      logic [RW-1:0]      r_row, w_row;
      logic [CW-1:0]      r_col, w_col, w_tcol;
      logic [SCALE_W-1:0] r_rsub, w_rsub, r_csub, w_csub;

      assign w_cx  = w_x[c*10 +: 10];
      assign w_cy  = w_y[c*10 +: 10];
      assign w_csc = w_sc[c*SCALE_W +: SCALE_W];

      // Counter state for the pixel on DrawX/DrawY; registers hold the previous pixel's state.
      always_comb begin
         w_ract = r_ract;
         w_row  = r_row;
         w_rsub = r_rsub;
         if (DrawX == 10'd0) begin
            if ((DrawY == w_cy) && (w_cy < 10'd480)) begin
               w_ract = 1'b1;
               w_row  = '0;
               w_rsub = '0;
            end else if ((DrawY >= 10'd480) || (DrawY == 10'd0)) begin
               w_ract = 1'b0;
            end else if (r_ract) begin
               if (r_rsub == w_csc) begin
                  w_rsub = '0;
                  if (r_row == RW'(SPR_H-1)) w_ract = 1'b0;
                  else                       w_row  = r_row + 1'b1;
               end else begin
                  w_rsub = r_rsub + 1'b1;
               end
            end
         end

         w_cact = r_cact;
         w_col  = r_col;
         w_csub = r_csub;
         if (w_ract && (DrawX == w_cx) && (w_cx < 10'd640)) begin
            w_cact = 1'b1;
            w_col  = '0;
            w_csub = '0;
         end else if (DrawX == 10'd0) begin
            w_cact = 1'b0;
         end else if (r_cact) begin
            if (r_csub == w_csc) begin
               w_csub = '0;
               if (r_col == CW'(SPR_W-1)) w_cact = 1'b0;
               else                       w_col  = r_col + 1'b1;
            end else begin
               w_csub = r_csub + 1'b1;
            end
         end
      end

      always_ff @(posedge vga_clk or posedge reset) begin
         if (reset) begin
            r_ract <= 1'b0;
            r_row  <= '0;
            r_rsub <= '0;
            r_cact <= 1'b0;
            r_col  <= '0;
            r_csub <= '0;
         end else begin
            r_ract <= w_ract;
            r_row  <= w_row;
            r_rsub <= w_rsub;
            r_cact <= w_cact;
            r_col  <= w_col;
            r_csub <= w_csub;
         end
      end

`ifdef SPRITE_FLIP_EN
      assign w_tcol = w_flip[c] ? (CW'(SPR_W-1) - w_col) : w_col;
`else
      assign w_tcol = w_col;
`endif

      assign w_hit[c] = w_en[c] & w_ract & w_cact & (DrawX < 10'd640) & (DrawY < 10'd480);
      assign w_addr[c*ADDR_W +: ADDR_W] = ADDR_W'(w_row) * ADDR_W'(SPR_W) + ADDR_W'(w_tcol);
   end

   // Lowest channel index wins, so scan downwards and let later matches overwrite.
   always_comb begin
      w_win     = 1'b0;
      w_win_idx = '0;
      w_win_ch  = '0;
      for (int c = NUM_CH-1; c >= 0; c--) begin
         if (r_hit2[c] && (rom_q[c*IDX_W +: IDX_W] != IDX_W'(TRANSP_IDX))) begin
            w_win     = 1'b1;
            w_win_idx = rom_q[c*IDX_W +: IDX_W];
            w_win_ch  = CH_W'(c);
         end
      end
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_hit1     <= '0;
         r_hit2     <= '0;
         r_blank1   <= 1'b0;
         r_blank2   <= 1'b0;
         rom_addr   <= '0;
         pix_idx    <= '0;
         pix_ch     <= '0;
         pix_opaque <= 1'b0;
         pix_blank  <= 1'b0;
      end else begin
         r_hit1   <= w_hit;
         r_hit2   <= r_hit1;
         r_blank1 <= blank;
         r_blank2 <= r_blank1;
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_hit[c]) rom_addr[c*ADDR_W +: ADDR_W] <= w_addr[c*ADDR_W +: ADDR_W];
         end
         pix_blank  <= r_blank2;
         pix_opaque <= r_blank2 & w_win;
         pix_idx    <= r_blank2 ? w_win_idx : '0;
         pix_ch     <= r_blank2 ? w_win_ch  : '0;
      end
   end
endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Directed bench for sprite_layer_renderer: table of single-pixel probes plus multi-cycle corner sequences.
module tb_sprite_layer_renderer;
   localparam int NUM_CH  = 4;
   localparam int ADDR_W  = 8;
   localparam int IDX_W   = 4;
   localparam int SCALE_W = 2;
   localparam int CH_W    = 2;
   localparam int NV      = 21;
`ifdef SPRITE_FLIP_EN
   localparam int FLIP = 1;
`else
   localparam int FLIP = 0;
`endif

   logic                      vga_clk = 1'b0;
   logic                      reset   = 1'b1;
   logic [9:0]                DrawX   = '0;
   logic [9:0]                DrawY   = '0;
   logic                      blank   = 1'b0;
   logic [NUM_CH-1:0]         ch_en   = '0;
   logic [NUM_CH*10-1:0]      ch_x    = '0;
   logic [NUM_CH*10-1:0]      ch_y    = '0;
   logic [NUM_CH*SCALE_W-1:0] ch_scale = '0;
   logic [NUM_CH-1:0]         ch_flip_h = '0;
   logic [NUM_CH*ADDR_W-1:0]  rom_addr;
   logic [NUM_CH*IDX_W-1:0]   rom_q = '0;
   logic [IDX_W-1:0]          pix_idx;
   logic [CH_W-1:0]           pix_ch;
   logic                      pix_opaque;
   logic                      pix_blank;

   logic [NUM_CH-1:0] rom_frc = '0;
   logic [IDX_W-1:0]  rom_val [NUM_CH];
   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      int en0, x0, y0, sc0, fl0;
      int en1, x1, y1;
      int frc0, val0;
      int tx, ty;
      int ach, eaddr;
      int eop, eidx, ech;
   } vec_t;
   vec_t vt [NV];

   sprite_layer_renderer dut (
      .vga_clk   (vga_clk),
      .reset     (reset),
      .DrawX     (DrawX),
      .DrawY     (DrawY),
      .blank     (blank),
      .ch_en     (ch_en),
      .ch_x      (ch_x),
      .ch_y      (ch_y),
      .ch_scale  (ch_scale),
      .ch_flip_h (ch_flip_h),
      .rom_addr  (rom_addr),
      .rom_q     (rom_q),
      .pix_idx   (pix_idx),
      .pix_ch    (pix_ch),
      .pix_opaque(pix_opaque),
      .pix_blank (pix_blank)
   );

   always #5 vga_clk = ~vga_clk;

   // External synchronous ROMs: texel = low address nibble with bit 0 forced, unless overridden.
   always @(posedge vga_clk) begin
      for (int c = 0; c < NUM_CH; c++)
         rom_q[c*IDX_W +: IDX_W] <= rom_frc[c] ? rom_val[c] : (rom_addr[c*ADDR_W +: 4] | 4'h1);
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input int x, input int y, input int b);
      DrawX = 10'(x);
      DrawY = 10'(y);
      blank = b[0];
      @(posedge vga_clk);
      #2;
   endtask

   task automatic set_ch(input int c, input int en, input int x, input int y, input int sc, input int fl);
      ch_en[c]                       = en[0];
      ch_x[c*10 +: 10]               = 10'(x);
      ch_y[c*10 +: 10]               = 10'(y);
      ch_scale[c*SCALE_W +: SCALE_W] = SCALE_W'(sc);
      ch_flip_h[c]                   = fl[0];
   endtask

   task automatic clear_ch();
      for (int c = 0; c < NUM_CH; c++) begin
         set_ch(c, 0, 0, 0, 0, 0);
         rom_val[c] = '0;
      end
      rom_frc = '0;
   endtask

   // Frame origin, one DrawX=0 cycle per line up to ty-1, then consecutive pixels on line ty up to tx-1.
   task automatic run_to(input int tx, input int ty);
      step(0, 0, 1);
      for (int y = 1; y < ty; y++) step(0, y, 1);
      for (int x = (ty == 0) ? 1 : 0; x < tx; x++) step(x, ty, 1);
   endtask

   task automatic probe(input vec_t v, input int i);
      clear_ch();
      set_ch(0, v.en0, v.x0, v.y0, v.sc0, v.fl0);
      set_ch(1, v.en1, v.x1, v.y1, 0, 0);
      rom_frc[0] = v.frc0[0];
      rom_val[0] = IDX_W'(v.val0);
      run_to(v.tx, v.ty);
      step(v.tx, v.ty, 1);
      if (v.eaddr >= 0)
         chk($sformatf("v%0d_rom_addr", i), int'(rom_addr[v.ach*ADDR_W +: ADDR_W]), v.eaddr);
      step(v.tx + 1, v.ty, 1);
      step(v.tx + 2, v.ty, 1);
      chk($sformatf("v%0d_pix_blank", i), int'(pix_blank), 1);
      chk($sformatf("v%0d_pix_opaque", i), int'(pix_opaque), v.eop);
      chk($sformatf("v%0d_pix_idx", i), int'(pix_idx), v.eidx);
      chk($sformatf("v%0d_pix_ch", i), int'(pix_ch), v.ech);
   endtask

   initial begin
      int seen;
      //         en0 x0  y0  sc fl en1 x1  y1 frc val tx  ty  ach addr op idx ch
      vt[0]  = '{1, 100, 50, 0, 0, 0, 0,   0,  0, 0, 100, 50, 0, 0,   1, 1,  0};
      vt[1]  = '{1, 100, 50, 0, 0, 0, 0,   0,  0, 0, 102, 50, 0, 2,   1, 3,  0};
      vt[2]  = '{1, 100, 50, 0, 0, 0, 0,   0,  0, 0, 115, 50, 0, 15,  1, 15, 0};
      vt[3]  = '{1, 100, 50, 0, 0, 0, 0,   0,  0, 0, 116, 50, 0, -1,  0, 0,  0};
      vt[4]  = '{1, 100, 50, 0, 0, 0, 0,   0,  0, 0, 105, 53, 0, 53,  1, 5,  0};
      vt[5]  = '{1, 100, 50, 0, 0, 0, 0,   0,  0, 0, 100, 65, 0, 240, 1, 1,  0};
      vt[6]  = '{1, 100, 50, 0, 0, 0, 0,   0,  0, 0, 100, 66, 0, -1,  0, 0,  0};
      vt[7]  = '{1, 100, 50, 0, 0, 0, 0,   0,  0, 0, 99,  50, 0, -1,  0, 0,  0};
      vt[8]  = '{1, 100, 50, 1, 0, 0, 0,   0,  0, 0, 100, 50, 0, 0,   1, 1,  0};
      vt[9]  = '{1, 100, 50, 1, 0, 0, 0,   0,  0, 0, 101, 50, 0, 0,   1, 1,  0};
      vt[10] = '{1, 100, 50, 1, 0, 0, 0,   0,  0, 0, 102, 51, 0, 1,   1, 1,  0};
      vt[11] = '{1, 100, 50, 1, 0, 0, 0,   0,  0, 0, 131, 52, 0, 31,  1, 15, 0};
      vt[12] = '{1, 100, 50, 1, 0, 0, 0,   0,  0, 0, 132, 52, 0, -1,  0, 0,  0};
      vt[13] = '{1, 100, 50, 1, 0, 0, 0,   0,  0, 0, 103, 52, 0, 17,  1, 1,  0};
      vt[14] = '{1, 200, 100, 0, 0, 1, 200, 100, 1, 0, 200, 100, 0, 0,  1, 1,  1};
      vt[15] = '{1, 200, 100, 0, 0, 1, 200, 100, 1, 5, 200, 100, 0, 0,  1, 5,  0};
      vt[16] = '{0, 200, 100, 0, 0, 1, 200, 100, 0, 0, 203, 101, 1, 19, 1, 3,  1};
      vt[17] = '{1, 630, 50, 0, 0, 0, 0,   0,  0, 0, 639, 50, 0, 9,   1, 9,  0};
      vt[18] = '{1, 100, 470, 0, 0, 0, 0,  0,  0, 0, 100, 479, 0, 144, 1, 1, 0};
      vt[19] = '{1, 0,   0,  0, 1, 0, 0,   0,  0, 0, 0,   0,  0, FLIP ? 15 : 0, 1, FLIP ? 15 : 1, 0};
      vt[20] = '{1, 640, 50, 0, 0, 0, 0,   0,  0, 0, 640, 50, 0, -1,  0, 0,  0};
      clear_ch();

      // Reset state
      step(0, 0, 1);
      chk("rst_rom_addr", int'(rom_addr), 0);
      chk("rst_pix_opaque", int'(pix_opaque), 0);
      chk("rst_pix_idx", int'(pix_idx), 0);
      chk("rst_pix_ch", int'(pix_ch), 0);
      chk("rst_pix_blank", int'(pix_blank), 0);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) probe(vt[i], i);

      // blank is delayed exactly three cycles and masks the pixel it accompanies
      clear_ch();
      set_ch(0, 1, 100, 50, 0, 0);
      run_to(100, 50);
      step(100, 50, 0);
      step(101, 50, 1);
      step(102, 50, 1);
      chk("blank_masked_blank", int'(pix_blank), 0);
      chk("blank_masked_opaque", int'(pix_opaque), 0);
      chk("blank_masked_idx", int'(pix_idx), 0);
      step(103, 50, 1);
      chk("blank_next_blank", int'(pix_blank), 1);
      chk("blank_next_opaque", int'(pix_opaque), 1);
      chk("blank_next_idx", int'(pix_idx), 1);

      // Reset mid-line: outputs clear immediately, nothing renders until the next frame origin
      clear_ch();
      set_ch(0, 1, 290, 50, 0, 0);
      run_to(300, 50);
      step(300, 50, 1);
      step(301, 50, 1);
      step(302, 50, 1);
      chk("midrst_before_opaque", int'(pix_opaque), 1);
      chk("midrst_before_idx", int'(pix_idx), 11);
      reset = 1'b1;
      #1;
      chk("midrst_now_opaque", int'(pix_opaque), 0);
      chk("midrst_now_idx", int'(pix_idx), 0);
      chk("midrst_now_blank", int'(pix_blank), 0);
      chk("midrst_now_rom_addr", int'(rom_addr), 0);
      @(posedge vga_clk);
      #2;
      reset = 1'b0;
      seen = 0;
      step(0, 51, 1);
      for (int x = 1; x < 320; x++) begin
         step(x, 51, 1);
         if (pix_opaque) seen = 1;
      end
      chk("midrst_rest_of_frame_opaque", seen, 0);
      run_to(300, 51);
      step(300, 51, 1);
      step(301, 51, 1);
      step(302, 51, 1);
      chk("midrst_next_frame_opaque", int'(pix_opaque), 1);
      chk("midrst_next_frame_idx", int'(pix_idx), 11);

      // Position change mid-frame takes effect only at the next frame origin
      clear_ch();
      set_ch(0, 1, 100, 190, 0, 0);
      step(0, 0, 1);
      for (int y = 1; y < 200; y++) step(0, y, 1);
      set_ch(0, 1, 300, 190, 0, 0);
      for (int x = 0; x < 100; x++) step(x, 200, 1);
      step(100, 200, 1);
      step(101, 200, 1);
      step(102, 200, 1);
      chk("tear_old_pos_opaque", int'(pix_opaque), 1);
      for (int x = 103; x < 300; x++) step(x, 200, 1);
      step(300, 200, 1);
      step(301, 200, 1);
      step(302, 200, 1);
      chk("tear_new_pos_same_frame", int'(pix_opaque), 0);
      run_to(300, 200);
      step(300, 200, 1);
      step(301, 200, 1);
      step(302, 200, 1);
      chk("tear_new_pos_next_frame", int'(pix_opaque), 1);

      // Sprite crossing the bottom edge does not wrap to the next frame
      clear_ch();
      set_ch(0, 1, 100, 470, 0, 0);
      step(0, 0, 1);
      for (int y = 1; y < 480; y++) step(0, y, 1);
      step(0, 500, 0);
      step(0, 0, 1);
      seen = 0;
      for (int x = 1; x < 120; x++) begin
         step(x, 0, 1);
         if (pix_opaque) seen = 1;
      end
      chk("bottom_no_wrap", seen, 0);

      // Shadow y beyond the visible area never renders
      clear_ch();
      set_ch(0, 1, 100, 490, 0, 0);
      step(0, 0, 1);
      for (int y = 1; y < 490; y++) step(0, y, 1);
      seen = 0;
      for (int x = 0; x < 120; x++) begin
         step(x, 490, 1);
         if (pix_opaque) seen = 1;
      end
      chk("y_offscreen_never", seen, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/sprite_layer_renderer.md
SPRITE_LAYER_RENDERER -- requirements
Module: sprite_layer_renderer

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent sprite channels (1..8).
REQ-002 Parameter SPR_W, default 16, sprite width in texels; SPR_H, default 16, sprite height in texels.
REQ-003 Parameter ADDR_W, default 8, ROM address width per channel, at least clog2(SPR_W*SPR_H); IDX_W, default 4, palette index width.
REQ-004 Parameter SCALE_W, default 2, per-channel scale field width; scale factor is field+1. TRANSP_IDX, default 0, transparent palette index.
REQ-005 vga_clk  input  1  pixel clock; all state is on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 DrawX, DrawY  input  10 each  current raster coordinates (0..799, 0..524).
REQ-008 blank  input  1  1 = active display region.
REQ-009 ch_en  input  NUM_CH  per-channel enable.
REQ-010 ch_x, ch_y  input  NUM_CH*10 each  per-channel top-left screen position.
REQ-011 ch_scale  input  NUM_CH*SCALE_W  per-channel integer scale minus one.
REQ-012 ch_flip_h  input  NUM_CH  per-channel horizontal mirror request.
REQ-013 rom_addr  output  NUM_CH*ADDR_W  registered texel address to each channel's external synchronous ROM.
REQ-014 rom_q  input  NUM_CH*IDX_W  ROM data, valid one vga_clk cycle after rom_addr.
REQ-015 pix_idx  output  IDX_W  winning palette index; pix_ch  output  clog2(NUM_CH) (min 1)  winning channel; pix_opaque  output  1  any channel opaque at this pixel; pix_blank  output  1  blank delayed to align.

Function
REQ-016 Shadow registers SHALL capture ch_en, ch_x, ch_y, ch_scale, ch_flip_h on the cycle DrawX==0 and DrawY==0; all rendering SHALL use shadow values only (no mid-frame tearing).
REQ-017 Per channel, on DrawX==0: if DrawY==shadow y then row=0, row_sub=0, row_act=1; else if row_act, row_sub increments; at row_sub==scale it wraps to 0 and row increments; after row SPR_H-1 completes, row_act=0.
REQ-018 Per channel, col_act SHALL set with col=0, col_sub=0 when row_act and DrawX==shadow x; col_sub/col advance identically per pixel; col_act clears after col SPR_W-1 completes or when DrawX==0.
REQ-019 Hit SHALL be en & row_act & col_act; rom_addr SHALL register row*SPR_W+col (cycle n+1 for DrawX/DrawY presented in cycle n); no hit holds the previous address.
REQ-020 Pipeline SHALL be 3 stages: hit and address registered at n+1, rom_q sampled at n+2 with delayed hit, outputs registered at n+3; pix_blank is blank delayed exactly 3 cycles.
REQ-021 Among channels with delayed hit and rom_q != TRANSP_IDX, lowest index SHALL win; none -> pix_opaque=0, pix_idx=0, pix_ch=0.
REQ-022 When delayed blank is 0, pix_opaque and pix_idx SHALL be 0.
REQ-023 Sprites extending past DrawX 639 or DrawY 479 SHALL clip with no wrap onto the next line or frame; shadow y >= 480 never renders.
REQ-024 Scale arithmetic SHALL use counters only; no multiplier or divider on DrawX/DrawY.

Reset
REQ-025 reset SHALL asynchronously clear all shadow registers, counters, active flags, pipeline registers, rom_addr, and all outputs to 0.
REQ-026 Reset released mid-frame: nothing SHALL render until the next DrawX==0, DrawY==0 shadow capture.

Configuration
REQ-027 Macro SPRITE_FLIP_EN defined: channels with shadow flip_h=1 SHALL address column SPR_W-1-col.
REQ-028 SPRITE_FLIP_EN undefined: ch_flip_h SHALL be ignored and no flip logic synthesised; port remains.

Verification
REQ-029 Reset asserted at DrawX=300 -> all outputs 0 the same cycle; no pixels until next frame origin.
REQ-030 ch0 at (100,50), scale 0, ROM returns addr[3:0]|1: DrawX=100,DrawY=50 in cycle n -> rom_addr=0 at n+1, pix_idx=1, pix_opaque=1 at n+3.
REQ-031 ch0 scale 1 at (100,50): DrawX 100..131 -> cols 0,0,1,1..15,15; DrawY 50,51 row 0, DrawY 52 row 1; DrawX 132 no hit.
REQ-032 ch0 and ch1 both at (200,100): ch0 rom_q=TRANSP_IDX -> pix_ch=1; ch0 rom_q=5 -> pix_ch=0, pix_idx=5.
REQ-033 ch_x changed 100->300 at DrawY=200 -> remainder of frame renders at 100, next frame at 300.
REQ-034 SPRITE_FLIP_EN defined, ch0 flip at (0,0) -> rom_addr=15 at DrawX=0; undefined -> rom_addr=0.
